// File: rtl/seg_pkg.sv
// Shared constants for the segment reader: active-low 7-segment patterns
// (bit6=g .. bit0=a) and the stability FSM encoding.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        LOCKED = 2'd2
    } readState_t;

endpackage

// File: rtl/seg_to_hex.sv
// Combinational inverse of the hex-to-7-segment encoder: maps an active-low
// segment pattern back to its nibble and flags blank or unknown patterns.
module seg_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] segIn,
    output logic [3:0] nibble,
    output logic       isValid,
    output logic       isBlank
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        nibble  = 4'h0;
        isValid = 1'b1;
        isBlank = 1'b0;
        case (segIn)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: begin
                isValid = 1'b0;
                isBlank = 1'b1;
            end
            default:   isValid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_reader.sv
// Samples a multiplexed active-low 7-segment bus, accepts a {digSel, segIn}
// pattern once it has been stable for STABLE_CYCLES enabled samples, and stores it per digit.
module seg_reader
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int IDX_W         = 2,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sampleEn,
    input  logic [6:0]              segIn,
    input  logic [IDX_W-1:0]        digSel,
    input  logic                    clrIn,
    output logic [4*NUM_DIGITS-1:0] hexOut,
    output logic [NUM_DIGITS-1:0]   digValid,
    output logic                    newDigit,
    output logic [IDX_W-1:0]        newIdx,
    output logic                    badPattern
);

    localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam bit              SINGLE   = (STABLE_CYCLES == 1);

    readState_t             state, nextState;
    logic [CNT_W-1:0]        cnt, nextCnt;
    logic [IDX_W-1:0]        sampSel, commitSel, nextIdx;
    logic [6:0]              sampSeg, commitSeg;
    logic                    match, capture, accept, selInRange;
    logic [3:0]              decNibble;
    logic                    decValid, decBlank;
    logic [4*NUM_DIGITS-1:0] nextHex;
    logic [NUM_DIGITS-1:0]   nextValid;
    logic                    nextNew, nextBad;

    assign match = (digSel == sampSel) && (segIn == sampSeg);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // A sample that differs from the held one (or any sample from IDLE) restarts the run.
    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        capture   = 1'b0;
        accept    = 1'b0;
        if (clrIn) begin
            nextState = IDLE;
            nextCnt   = '0;
        end else if (sampleEn) begin
            if (state == IDLE || !match) begin
                capture = 1'b1;
                nextCnt = CNT_ONE;
                if (SINGLE) begin
                    accept    = 1'b1;
                    nextState = LOCKED;
                end else begin
                    nextState = COUNT;
                end
            end else if (state == COUNT) begin
                nextCnt = cnt + CNT_ONE;
                if (cnt == CNT_LAST) begin
                    accept    = 1'b1;
                    nextState = LOCKED;
                end
            end
        end
    end

    // Decode whatever the sample register holds after this edge, so a
    // single-cycle accept sees the fresh input rather than the stale capture.
    assign commitSel  = capture ? digSel : sampSel;
    assign commitSeg  = capture ? segIn  : sampSeg;
    assign selInRange = int'(commitSel) < NUM_DIGITS;

    seg_to_hex uDecode (
        .segIn   (commitSeg),
        .nibble  (decNibble),
        .isValid (decValid),
        .isBlank (decBlank)
    );

    always_comb begin
        nextHex   = hexOut;
        nextValid = digValid;
        nextNew   = 1'b0;
        nextBad   = 1'b0;
        nextIdx   = newIdx;
        if (clrIn) begin
            nextHex   = '0;
            nextValid = '0;
        end else if (accept) begin
            if (!selInRange || !(decValid || decBlank)) begin
                nextBad = 1'b1;
                nextIdx = commitSel;
            end else if (decValid) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (int'(commitSel) == k) begin
                        nextHex[4*k +: 4] = decNibble;
                        nextValid[k]      = 1'b1;
                    end
                end
                nextNew = 1'b1;
                nextIdx = commitSel;
            end else begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (int'(commitSel) == k) nextValid[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            sampSel    <= '0;
            sampSeg    <= '0;
            hexOut     <= '0;
            digValid   <= '0;
            newDigit   <= 1'b0;
            badPattern <= 1'b0;
            newIdx     <= '0;
        end else begin
            cnt <= nextCnt;
            if (capture) begin
                sampSel <= digSel;
                sampSeg <= segIn;
            end
            hexOut     <= nextHex;
            digValid   <= nextValid;
            newDigit   <= nextNew;
            badPattern <= nextBad;
            newIdx     <= nextIdx;
        end
    end

endmodule
